pic_fetch: RTL

Instruction-fetch stage of the structural 12-bit-instruction PIC core, sitting directly upstream of the combinational program ROM (9-bit address, 12-bit word) and feeding the decode/execute stage. It owns the program counter, the instruction register and the 2-level hardware return stack. It resolves GOTO, CALL and RETLW locally, and accepts skip and PC-write requests from execute. Every flow change costs one flushed (NOP) slot, giving the PIC's two-cycle branch timing.

---
 rtl/pic_pkg.sv | 47 ++++
 rtl/pic_fetch_if.sv | 26 ++
 rtl/pic_stack.sv | 40 ++++
 rtl/pic_fetch.sv | 90 +++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared constants, opcode decode and types for the PIC fetch stage.
// Flow-change opcodes are matched with a mask/match pair on the instruction register.
package pic_pkg;

   localparam int PC_W    = 9;
   localparam int INSTR_W = 12;

   localparam logic [INSTR_W-1:0] NOP = 12'h000;

   localparam logic [INSTR_W-1:0] GOTO_MASK   = 12'hE00;
   localparam logic [INSTR_W-1:0] GOTO_MATCH  = 12'hA00;
   localparam logic [INSTR_W-1:0] CALL_MASK   = 12'hF00;
   localparam logic [INSTR_W-1:0] CALL_MATCH  = 12'h900;
   localparam logic [INSTR_W-1:0] RETLW_MASK  = 12'hF00;
   localparam logic [INSTR_W-1:0] RETLW_MATCH = 12'h800;

   localparam logic [PC_W-1:0] DEFAULT_RESET_VECTOR = 9'h000;

   typedef enum logic [1:0] {
      FLOW_SEQ,
      FLOW_GOTO,
      FLOW_CALL,
      FLOW_RET
   } flow_t;

   typedef enum logic [1:0] {
      DEPTH_EMPTY,
      DEPTH_ONE,
      DEPTH_TWO
   } depth_t;

   // A flushed slot never redirects, whatever word happens to sit in the IR.
   function automatic flow_t decodeFlow(input logic [INSTR_W-1:0] instr, input logic valid);
      flow_t f;
      f = FLOW_SEQ;
      if (valid) begin
         if ((instr & GOTO_MASK) == GOTO_MATCH)
            f = FLOW_GOTO;
         else if ((instr & CALL_MASK) == CALL_MATCH)
            f = FLOW_CALL;
         else if ((instr & RETLW_MASK) == RETLW_MATCH)
            f = FLOW_RET;
      end
      return f;
   endfunction

endpackage

// File: rtl/pic_fetch_if.sv
// Fetch-stage bus: execute requests and ROM data in, PC/IR/trace out.
// The master side is the fetch stage; the slave side is execute plus ROM.
interface pic_fetch_if;
   import pic_pkg::*;

   logic               stall;
   logic               skip;
   logic               pcWrite;
   logic [PC_W-1:0]    pcWrData;
   logic [INSTR_W-1:0] romData;
   logic [PC_W-1:0]    romAddr;
   logic [INSTR_W-1:0] instr;
   logic               instrValid;
   logic [PC_W-1:0]    instrAddr;
   logic               stackOverflow;

   modport master (
      input  stall, skip, pcWrite, pcWrData, romData,
      output romAddr, instr, instrValid, instrAddr, stackOverflow
   );

   modport slave (
      output stall, skip, pcWrite, pcWrData, romData,
      input  romAddr, instr, instrValid, instrAddr, stackOverflow
   );
endinterface

// File: rtl/pic_stack.sv
// Two-entry hardware return stack with a sticky overflow flag.
// Popping an empty stack returns the stale top entry without complaint, as the silicon does.
module pic_stack
   import pic_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] pushData,
   output logic [PC_W-1:0] top,
   output logic            overflow
);

   logic [PC_W-1:0] s0;
   logic [PC_W-1:0] s1;
   depth_t          depth;

   // Push and pop are mutually exclusive; the caller decodes one opcode per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0       <= '0;
         s1       <= '0;
         depth    <= DEPTH_EMPTY;
         overflow <= 1'b0;
      end else if (push) begin
         s1 <= s0;
         s0 <= pushData;
         if (depth == DEPTH_TWO)
            overflow <= 1'b1;
         depth <= (depth == DEPTH_EMPTY) ? DEPTH_ONE : DEPTH_TWO;
      end else if (pop) begin
         s0    <= s1;
         depth <= (depth == DEPTH_TWO) ? DEPTH_ONE : DEPTH_EMPTY;
      end
   end

   assign top = s0;

endmodule

// File: rtl/pic_fetch.sv
// Instruction-fetch stage: owns PC, IR and return stack, and resolves GOTO/CALL/RETLW.
// Every flow change inserts one flushed slot, which gives the two-cycle branch timing.
module pic_fetch
   import pic_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
)(
   input logic         clk,
   input logic         rst,
   pic_fetch_if.master bus
);

   logic [PC_W-1:0]    pc;
   logic [PC_W-1:0]    pcInc;
   logic [PC_W-1:0]    flowTarget;
   logic [INSTR_W-1:0] instrQ;
   logic               validQ;
   logic [PC_W-1:0]    addrQ;
   logic [PC_W-1:0]    stackTop;
   logic               stackOverflow;
   logic               push;
   logic               pop;
   flow_t              flow;

   assign pcInc = pc + 9'd1;
   assign flow  = decodeFlow(instrQ, validQ);
   assign push  = !bus.stall && (flow == FLOW_CALL);
   assign pop   = !bus.stall && (flow == FLOW_RET);

   always_comb begin
      flowTarget = pcInc;
      case (flow)
         FLOW_GOTO: flowTarget = instrQ[PC_W-1:0];
         FLOW_CALL: flowTarget = {1'b0, instrQ[7:0]};
         FLOW_RET:  flowTarget = stackTop;
         default:   flowTarget = pcInc;
      endcase
   end

   // At CALL decode the PC already holds InstrAddr+1, so it is pushed as the return address.
   pic_stack u_stack (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .pushData (pc),
      .top      (stackTop),
      .overflow (stackOverflow)
   );

   // Priority: decoded flow change, then execute PC write, then skip, else sequential fetch.
   // Execute requests are only honoured against a valid slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc     <= RESET_VECTOR;
         instrQ <= NOP;
         validQ <= 1'b0;
         addrQ  <= RESET_VECTOR;
      end else if (!bus.stall) begin
         if (flow != FLOW_SEQ) begin
            pc     <= flowTarget;
            instrQ <= NOP;
            validQ <= 1'b0;
            addrQ  <= pc;
         end else if (bus.pcWrite && validQ) begin
            pc     <= bus.pcWrData;
            instrQ <= NOP;
            validQ <= 1'b0;
            addrQ  <= pc;
         end else if (bus.skip && validQ) begin
            pc     <= pcInc;
            instrQ <= NOP;
            validQ <= 1'b0;
            addrQ  <= pc;
         end else begin
            pc     <= pcInc;
            instrQ <= bus.romData;
            validQ <= 1'b1;
            addrQ  <= pc;
         end
      end
   end

   assign bus.romAddr       = pc;
   assign bus.instr         = instrQ;
   assign bus.instrValid    = validQ;
   assign bus.instrAddr     = addrQ;
   assign bus.stackOverflow = stackOverflow;

endmodule
